// File: rtl/mem_controller_pkg.sv
// Shared definitions for the unified RAM port controller: state encoding,
// access-size encodings and the address-geometry defaults used by the ICache.
package mem_controller_pkg;

   localparam int DEF_ADDR_WIDTH  = 17;
   localparam int DEF_BLOCK_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      IFETCH = 2'b01,
      DREAD  = 2'b10,
      DWRITE = 2'b11
   } ctrlState_t;

   localparam logic [1:0] SIZE_BYTE    = 2'b00;
   localparam logic [1:0] SIZE_HALF    = 2'b01;
   localparam logic [1:0] SIZE_WORD    = 2'b10;
   localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

   // The illegal encoding falls through to a full word.
   function automatic logic [2:0] sizeToBytes(input logic [1:0] size);
      logic [2:0] count;
      case (size)
         SIZE_BYTE: count = 3'd1;
         SIZE_HALF: count = 3'd2;
         SIZE_WORD: count = 3'd4;
         default:   count = 3'd4;
      endcase
      return count;
   endfunction

endpackage

// File: rtl/mem_controller_byte_assembler.sv
// Collects RAM read bytes into lanes; the merged view already contains the
// byte being captured this cycle so a completion register can load it directly.
module byte_assembler #(
   parameter int LANES  = 16,
   parameter int LANE_W = 4
)(
   input  logic                 clkIn,
   input  logic                 resetIn,
   input  logic                 clear,
   input  logic                 capture,
   input  logic [LANE_W-1:0]    lane,
   input  logic [7:0]           byteIn,
   output logic [LANES*8-1:0]   merged
);

   logic [LANES*8-1:0] laneR;

   // Overlay the incoming byte onto its lane.
   always_comb begin
      merged = laneR;
      if (capture) begin
         merged[{lane, 3'b000} +: 8] = byteIn;
      end else begin
         merged = laneR;
      end
   end

   // Lane storage; cleared at each acceptance so unread lanes read as zero.
   always_ff @(posedge clkIn) begin
      if (resetIn) begin
         laneR <= '0;
      end else if (clear) begin
         laneR <= '0;
      end else begin
         laneR <= merged;
      end
   end

endmodule

// File: rtl/mem_controller_checker.sv
// Simulation-only properties on the controller's request and completion ports.
module mem_controller_checker
   import mem_controller_pkg::*;
(
   input logic       clkIn,
   input logic       resetIn,
   input logic       dataReq,
   input logic [1:0] dataSize,
   input logic       dataDone,
   input logic       icacheValid
);

   assert property (@(posedge clkIn) disable iff (resetIn)
      dataReq |-> (dataSize != SIZE_ILLEGAL));

   assert property (@(posedge clkIn) disable iff (resetIn)
      dataDone |=> !dataDone);

   assert property (@(posedge clkIn) disable iff (resetIn)
      icacheValid |=> !icacheValid);

   assert property (@(posedge clkIn) disable iff (resetIn)
      !(dataDone && icacheValid));

endmodule

// File: rtl/mem_controller.sv
// Owner of the byte-wide RAM port: serves ICache block refills and LSU
// byte/half/word accesses, LSU first, with one-cycle completion pulses.
module mem_controller
   import mem_controller_pkg::*;
#(
   parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int BLOCK_WIDTH = DEF_BLOCK_WIDTH,
   parameter int BLOCK_SIZE  = 2**BLOCK_WIDTH
)(
   input  logic                          clkIn,
   input  logic                          resetIn,
   input  logic                          icacheReq,
   input  logic [ADDR_WIDTH-BLOCK_WIDTH-1:0] icacheAddr,
   output logic                          icacheValid,
   output logic [ADDR_WIDTH-BLOCK_WIDTH-1:0] icacheBlockAddr,
   output logic [BLOCK_SIZE*8-1:0]       icacheData,
   input  logic                          dataReq,
   input  logic                          dataWrite,
   input  logic [ADDR_WIDTH-1:0]         dataAddr,
   input  logic [1:0]                    dataSize,
   input  logic [31:0]                   dataIn,
   output logic                          dataDone,
   output logic [31:0]                   dataOut,
   input  logic [7:0]                    memIn,
   output logic [7:0]                    memOut,
   output logic [ADDR_WIDTH-1:0]         memAddr,
   output logic                          memWrite
);

   localparam int CNT_W = BLOCK_WIDTH + 1;
   localparam int TAG_W = ADDR_WIDTH - BLOCK_WIDTH;

   ctrlState_t             stateR, stateS;
   logic [CNT_W-1:0]       cntR, cntS, cntIncS;
   logic [TAG_W-1:0]       blkR, blkS;
   logic [ADDR_WIDTH-1:0]  baseR, baseS;
   logic [2:0]             bytesR, bytesS;
   logic [31:0]            wdataR, wdataS;

   logic [ADDR_WIDTH-1:0]  memAddrS;
   logic [7:0]             memOutS;
   logic                   memWriteS, icacheValidS, dataDoneS;
   logic [31:0]            dataOutS;
   logic [BLOCK_SIZE*8-1:0] icacheDataS;
   logic [TAG_W-1:0]       icacheBlockAddrS;

   logic                   clearS, captureS, dataAccS, icAccS;
   logic [BLOCK_WIDTH-1:0] laneS;
   logic [BLOCK_SIZE*8-1:0] mergedS;

   // RAM data lags its address by one cycle, so the capture lane trails the counter.
   assign laneS   = cntR[BLOCK_WIDTH-1:0] - BLOCK_WIDTH'(1);
   assign cntIncS = cntR + CNT_W'(1);
   // A requester still holding its request during its own completion cycle is ignored.
   assign dataAccS = dataReq && !dataDone;
   assign icAccS   = icacheReq && !icacheValid;

   byte_assembler #(
      .LANES  (BLOCK_SIZE),
      .LANE_W (BLOCK_WIDTH)
   ) assembler (
      .clkIn   (clkIn),
      .resetIn (resetIn),
      .clear   (clearS),
      .capture (captureS),
      .lane    (laneS),
      .byteIn  (memIn),
      .merged  (mergedS)
   );

   mem_controller_checker checker0 (
      .clkIn       (clkIn),
      .resetIn     (resetIn),
      .dataReq     (dataReq),
      .dataSize    (dataSize),
      .dataDone    (dataDone),
      .icacheValid (icacheValid)
   );

   // Next-state and next-output computation for every registered output.
   always_comb begin
      stateS           = stateR;
      cntS             = cntR;
      blkS             = blkR;
      baseS            = baseR;
      bytesS           = bytesR;
      wdataS           = wdataR;
      memAddrS         = memAddr;
      memOutS          = memOut;
      memWriteS        = 1'b0;
      icacheValidS     = 1'b0;
      dataDoneS        = 1'b0;
      dataOutS         = dataOut;
      icacheDataS      = icacheData;
      icacheBlockAddrS = icacheBlockAddr;
      clearS           = 1'b0;
      captureS         = 1'b0;

      case (stateR)
         IDLE: begin
            if (dataAccS) begin
               baseS    = dataAddr;
               bytesS   = sizeToBytes(dataSize);
               wdataS   = dataIn;
               cntS     = '0;
               memAddrS = dataAddr;
               clearS   = 1'b1;
               if (dataWrite) begin
                  stateS    = DWRITE;
                  memWriteS = 1'b1;
                  memOutS   = dataIn[7:0];
               end else begin
                  stateS = DREAD;
               end
            end else if (icAccS) begin
               blkS     = icacheAddr;
               cntS     = '0;
               memAddrS = {icacheAddr, {BLOCK_WIDTH{1'b0}}};
               clearS   = 1'b1;
               stateS   = IFETCH;
            end else begin
               stateS = IDLE;
            end
         end

         IFETCH: begin
            cntS     = cntIncS;
            captureS = (cntR != '0);
            if (cntR < CNT_W'(BLOCK_SIZE - 1)) begin
               memAddrS = {blkR, cntIncS[BLOCK_WIDTH-1:0]};
            end else begin
               memAddrS = memAddr;
            end
            if (cntR == CNT_W'(BLOCK_SIZE)) begin
               stateS           = IDLE;
               cntS             = '0;
               icacheValidS     = 1'b1;
               icacheDataS      = mergedS;
               icacheBlockAddrS = blkR;
            end else begin
               stateS = IFETCH;
            end
         end

         DREAD: begin
            cntS     = cntIncS;
            captureS = (cntR != '0);
            if (cntIncS < CNT_W'(bytesR)) begin
               memAddrS = baseR + ADDR_WIDTH'(cntIncS);
            end else begin
               memAddrS = memAddr;
            end
            if (cntR == CNT_W'(bytesR)) begin
               stateS    = IDLE;
               cntS      = '0;
               dataDoneS = 1'b1;
               dataOutS  = mergedS[31:0];
            end else begin
               stateS = DREAD;
            end
         end

         DWRITE: begin
            cntS = cntIncS;
            if (cntIncS < CNT_W'(bytesR)) begin
               memWriteS = 1'b1;
               memAddrS  = baseR + ADDR_WIDTH'(cntIncS);
               memOutS   = wdataR[{cntIncS[1:0], 3'b000} +: 8];
            end else begin
               stateS    = IDLE;
               cntS      = '0;
               dataDoneS = 1'b1;
            end
         end

         default: begin
            stateS = IDLE;
            cntS   = '0;
         end
      endcase
   end

   // State, request latches and all outputs.
   always_ff @(posedge clkIn) begin
      if (resetIn) begin
         stateR          <= IDLE;
         cntR            <= '0;
         blkR            <= '0;
         baseR           <= '0;
         bytesR          <= 3'd0;
         wdataR          <= 32'd0;
         memAddr         <= '0;
         memOut          <= 8'd0;
         memWrite        <= 1'b0;
         icacheValid     <= 1'b0;
         dataDone        <= 1'b0;
         dataOut         <= 32'd0;
         icacheData      <= '0;
         icacheBlockAddr <= '0;
      end else begin
         stateR          <= stateS;
         cntR            <= cntS;
         blkR            <= blkS;
         baseR           <= baseS;
         bytesR          <= bytesS;
         wdataR          <= wdataS;
         memAddr         <= memAddrS;
         memOut          <= memOutS;
         memWrite        <= memWriteS;
         icacheValid     <= icacheValidS;
         dataDone        <= dataDoneS;
         dataOut         <= dataOutS;
         icacheData      <= icacheDataS;
         icacheBlockAddr <= icacheBlockAddrS;
      end
   end

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller with a byte RAM model (one-cycle read latency).
module tb_mem_controller;

   logic         clkIn = 1'b0;
   logic         resetIn;
   logic         icacheReq;
   logic [12:0]  icacheAddr;
   logic         icacheValid;
   logic [12:0]  icacheBlockAddr;
   logic [127:0] icacheData;
   logic         dataReq;
   logic         dataWrite;
   logic [16:0]  dataAddr;
   logic [1:0]   dataSize;
   logic [31:0]  dataIn;
   logic         dataDone;
   logic [31:0]  dataOut;
   logic [7:0]   memIn;
   logic [7:0]   memOut;
   logic [16:0]  memAddr;
   logic         memWrite;

   logic [7:0]   ram [0:131071];
   logic         tbWe;
   logic [16:0]  tbAddr;
   logic [7:0]   tbData;

   int tests = 0;
   int fails = 0;

   always #5 clkIn = ~clkIn;

   mem_controller dut (
      .clkIn           (clkIn),
      .resetIn         (resetIn),
      .icacheReq       (icacheReq),
      .icacheAddr      (icacheAddr),
      .icacheValid     (icacheValid),
      .icacheBlockAddr (icacheBlockAddr),
      .icacheData      (icacheData),
      .dataReq         (dataReq),
      .dataWrite       (dataWrite),
      .dataAddr        (dataAddr),
      .dataSize        (dataSize),
      .dataIn          (dataIn),
      .dataDone        (dataDone),
      .dataOut         (dataOut),
      .memIn           (memIn),
      .memOut          (memOut),
      .memAddr         (memAddr),
      .memWrite        (memWrite)
   );

   always @(posedge clkIn) begin
      if (tbWe) ram[tbAddr] <= tbData;
      else if (memWrite) ram[memAddr] <= memOut;
      memIn <= ram[memAddr];
   end

   task automatic preload(input logic [16:0] a, input logic [7:0] d);
      tbAddr = a; tbData = d; tbWe = 1'b1;
      @(posedge clkIn); #1;
      tbWe = 1'b0;
   endtask

   task automatic test_reset();
      resetIn = 1'b1; icacheReq = 1'b0; icacheAddr = 13'h0; dataReq = 1'b0;
      dataWrite = 1'b0; dataAddr = 17'h0; dataSize = 2'b00; dataIn = 32'h0; tbWe = 1'b0;
      tbAddr = 17'h0; tbData = 8'h0;
      @(posedge clkIn); #1;
      for (int k = 0; k < 16; k++) preload({13'h0123, 4'(k)}, 8'(8'h10 + k));
      for (int k = 0; k < 16; k++) preload({13'h0045, 4'(k)}, 8'(8'h40 + k));
      preload(17'h00104, 8'hAA); preload(17'h00105, 8'hBB);
      preload(17'h00106, 8'hCC); preload(17'h00107, 8'hDD);
      preload(17'h00200, 8'h11); preload(17'h00201, 8'h22);
      preload(17'h00202, 8'h33); preload(17'h00203, 8'h44);
      @(negedge clkIn);
      tests++; if (icacheValid !== 1'b0) begin fails++; $display("FAIL reset_icacheValid got %h want 0", icacheValid); end
      tests++; if (dataDone !== 1'b0) begin fails++; $display("FAIL reset_dataDone got %h want 0", dataDone); end
      tests++; if (memWrite !== 1'b0) begin fails++; $display("FAIL reset_memWrite got %h want 0", memWrite); end
      tests++; if (memAddr !== 17'h0) begin fails++; $display("FAIL reset_memAddr got %h want 0", memAddr); end
      tests++; if (memOut !== 8'h0) begin fails++; $display("FAIL reset_memOut got %h want 0", memOut); end
      tests++; if (dataOut !== 32'h0) begin fails++; $display("FAIL reset_dataOut got %h want 0", dataOut); end
      tests++; if (icacheData !== 128'h0) begin fails++; $display("FAIL reset_icacheData got %h want 0", icacheData); end
      tests++; if (icacheBlockAddr !== 13'h0) begin fails++; $display("FAIL reset_blockAddr got %h want 0", icacheBlockAddr); end
      resetIn = 1'b0;
   endtask

   task automatic test_refill(input logic [12:0] blk, input logic [127:0] expData);
      @(posedge clkIn); #1;
      icacheAddr = blk; icacheReq = 1'b1;
      @(posedge clkIn);
      for (int cyc = 0; cyc <= 20; cyc++) begin
         logic [16:0] ea;
         @(negedge clkIn);
         ea = (cyc <= 15) ? {blk, 4'(cyc)} : {blk, 4'hF};
         tests++; if (memAddr !== ea) begin fails++; $display("FAIL refill_addr cyc %0d got %h want %h", cyc, memAddr, ea); end
         tests++; if (memWrite !== 1'b0) begin fails++; $display("FAIL refill_memWrite cyc %0d got %h want 0", cyc, memWrite); end
         tests++; if (icacheValid !== (cyc == 17)) begin fails++; $display("FAIL refill_valid cyc %0d got %h want %h", cyc, icacheValid, (cyc == 17)); end
         if (cyc == 17) begin
            tests++; if (icacheData !== expData) begin fails++; $display("FAIL refill_data got %h want %h", icacheData, expData); end
            tests++; if (icacheBlockAddr !== blk) begin fails++; $display("FAIL refill_blockAddr got %h want %h", icacheBlockAddr, blk); end
         end
         if (cyc == 18) icacheReq = 1'b0;
      end
   endtask

   task automatic test_load(input logic [16:0] addr, input logic [1:0] size, input int n, input logic [31:0] expOut);
      @(posedge clkIn); #1;
      dataAddr = addr; dataSize = size; dataWrite = 1'b0; dataReq = 1'b1;
      @(posedge clkIn);
      for (int cyc = 0; cyc <= n + 2; cyc++) begin
         logic [16:0] ea;
         @(negedge clkIn);
         ea = (cyc < n) ? addr + 17'(cyc) : addr + 17'(n - 1);
         tests++; if (memAddr !== ea) begin fails++; $display("FAIL load_addr cyc %0d got %h want %h", cyc, memAddr, ea); end
         tests++; if (memWrite !== 1'b0) begin fails++; $display("FAIL load_memWrite cyc %0d got %h want 0", cyc, memWrite); end
         tests++; if (dataDone !== (cyc == n + 1)) begin fails++; $display("FAIL load_done cyc %0d got %h want %h", cyc, dataDone, (cyc == n + 1)); end
         if (cyc == n + 1) begin
            tests++; if (dataOut !== expOut) begin fails++; $display("FAIL load_data got %h want %h", dataOut, expOut); end
            dataReq = 1'b0;
         end
      end
   endtask

   task automatic test_store_wrap();
      @(posedge clkIn); #1;
      dataAddr = 17'h1FFFF; dataSize = 2'b01; dataWrite = 1'b1; dataIn = 32'h0000BEEF; dataReq = 1'b1;
      @(posedge clkIn);
      for (int cyc = 0; cyc <= 3; cyc++) begin
         @(negedge clkIn);
         tests++; if (memWrite !== (cyc < 2)) begin fails++; $display("FAIL store_memWrite cyc %0d got %h want %h", cyc, memWrite, (cyc < 2)); end
         tests++; if (dataDone !== (cyc == 2)) begin fails++; $display("FAIL store_done cyc %0d got %h want %h", cyc, dataDone, (cyc == 2)); end
         if (cyc == 0) begin
            tests++; if (memAddr !== 17'h1FFFF) begin fails++; $display("FAIL store_addr0 got %h want 1ffff", memAddr); end
            tests++; if (memOut !== 8'hEF) begin fails++; $display("FAIL store_byte0 got %h want ef", memOut); end
         end
         if (cyc == 1) begin
            tests++; if (memAddr !== 17'h00000) begin fails++; $display("FAIL store_addr1 got %h want 00000", memAddr); end
            tests++; if (memOut !== 8'hBE) begin fails++; $display("FAIL store_byte1 got %h want be", memOut); end
         end
         if (cyc == 2) dataReq = 1'b0;
      end
      tests++; if (ram[17'h1FFFF] !== 8'hEF) begin fails++; $display("FAIL store_ram_top got %h want ef", ram[17'h1FFFF]); end
      tests++; if (ram[17'h00000] !== 8'hBE) begin fails++; $display("FAIL store_ram_wrap got %h want be", ram[17'h00000]); end
      dataWrite = 1'b0;
   endtask

   task automatic test_contention();
      @(posedge clkIn); #1;
      dataAddr = 17'h00200; dataSize = 2'b10; dataWrite = 1'b0; dataReq = 1'b1;
      icacheAddr = 13'h0045; icacheReq = 1'b1;
      @(posedge clkIn);
      for (int cyc = 0; cyc <= 25; cyc++) begin
         logic [16:0] ea;
         @(negedge clkIn);
         if (cyc < 4) ea = 17'h00200 + 17'(cyc);
         else if (cyc < 6) ea = 17'h00203;
         else if (cyc <= 21) ea = {13'h0045, 4'(cyc - 6)};
         else ea = {13'h0045, 4'hF};
         tests++; if (memAddr !== ea) begin fails++; $display("FAIL contend_addr cyc %0d got %h want %h", cyc, memAddr, ea); end
         tests++; if (memWrite !== 1'b0) begin fails++; $display("FAIL contend_memWrite cyc %0d got %h want 0", cyc, memWrite); end
         tests++; if (dataDone !== (cyc == 5)) begin fails++; $display("FAIL contend_done cyc %0d got %h want %h", cyc, dataDone, (cyc == 5)); end
         tests++; if (icacheValid !== (cyc == 23)) begin fails++; $display("FAIL contend_valid cyc %0d got %h want %h", cyc, icacheValid, (cyc == 23)); end
         if (cyc == 5) begin
            tests++; if (dataOut !== 32'h44332211) begin fails++; $display("FAIL contend_data got %h want 44332211", dataOut); end
            dataReq = 1'b0;
         end
         if (cyc == 23) begin
            tests++; if (icacheData !== 128'h4F4E4D4C4B4A49484746454443424140) begin fails++; $display("FAIL contend_block got %h", icacheData); end
         end
         if (cyc == 24) icacheReq = 1'b0;
      end
   endtask

   task automatic test_reset_mid_refill();
      @(posedge clkIn); #1;
      icacheAddr = 13'h0077; icacheReq = 1'b1;
      @(posedge clkIn);
      for (int cyc = 0; cyc <= 7; cyc++) begin
         @(negedge clkIn);
         tests++; if (memAddr !== {13'h0077, 4'(cyc)}) begin fails++; $display("FAIL abort_addr cyc %0d got %h want %h", cyc, memAddr, {13'h0077, 4'(cyc)}); end
      end
      resetIn = 1'b1; icacheReq = 1'b0;
      @(negedge clkIn);
      tests++; if (memAddr !== 17'h0) begin fails++; $display("FAIL abort_memAddr got %h want 0", memAddr); end
      tests++; if (icacheValid !== 1'b0) begin fails++; $display("FAIL abort_valid got %h want 0", icacheValid); end
      tests++; if (icacheData !== 128'h0) begin fails++; $display("FAIL abort_data got %h want 0", icacheData); end
      resetIn = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clkIn);
         tests++; if (icacheValid !== 1'b0) begin fails++; $display("FAIL abort_no_pulse cyc %0d got %h want 0", cyc, icacheValid); end
      end
   endtask

   initial begin
      test_reset();
      test_refill(13'h0123, 128'h1F1E1D1C1B1A19181716151413121110);
      test_load(17'h00104, 2'b10, 4, 32'hDDCCBBAA);
      test_load(17'h00104, 2'b00, 1, 32'h000000AA);
      test_store_wrap();
      test_contention();
      test_reset_mid_refill();
      test_refill(13'h0123, 128'h1F1E1D1C1B1A19181716151413121110);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
